ahb_bm_input_stage: RTL and testbench



---
 rtl/ahb_bm_pkg.sv | 31 +++
 rtl/ahb_bm_hold_reg.sv | 52 +++++
 rtl/ahb_bm_input_stage.sv | 152 +++++++++++++++
 tb/tb_ahb_bm_input_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// rtl/ahb_bm_pkg.sv - shared AHB bus-matrix encodings and address-phase control bundle
//
// Purpose: HTRANS/HRESP encodings, the packed control part of an AHB address
// phase, and a helper that tells whether a transfer type carries data.
// The address and user fields are carried beside this bundle because their
// widths are per-instance parameters.
package ahb_bm_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       mastlock;
    } ahb_ctrl_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_bm_hold_reg.sv
// rtl/ahb_bm_hold_reg.sv - load-enabled holding register for one AHB address phase
//
// Purpose: stores the address, user and control fields of a transfer that
// could not be issued immediately.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset, clears every field
//   i_load     capture i_addr/i_auser/i_ctrl at this edge
//   i_addr     address to capture
//   i_auser    address user field to capture
//   i_ctrl     control bundle to capture
//   o_addr     held address
//   o_auser    held address user field
//   o_ctrl     held control bundle
module ahb_bm_hold_reg
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int AUSER_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [AUSER_WIDTH-1:0] i_auser,
    input  ahb_ctrl_t              i_ctrl,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic [AUSER_WIDTH-1:0] o_auser,
    output ahb_ctrl_t              o_ctrl
);

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [AUSER_WIDTH-1:0] r_auser;
    ahb_ctrl_t              r_ctrl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_auser <= '0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_auser <= i_auser;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_addr  = r_addr;
    assign o_auser = r_auser;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/ahb_bm_input_stage.sv
// rtl/ahb_bm_input_stage.sv - per-master input stage of the AHB bus matrix
//
// Purpose: passes the master address phase straight to the decoder when the
// target output stage accepts it; otherwise captures it, stalls the master
// and re-presents the held copy until the output stage takes it. Returns the
// decoder's data-phase response to the master.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   HSELS..HAUSERS, HREADYS      master-side address phase and bus ready
//   active_op                    decoder accepts the presented transfer
//   readyout_op, resp_op         decoder data-phase ready/response
//   sel_op..auser_op, ready_op   address phase / HREADY presented to decoder
//   held_tran_op                 held copy is being presented
//   HREADYOUTS, HRESPS           ready/response to the master
module ahb_bm_input_stage
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int AUSER_WIDTH = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSELS,
    input  logic [ADDR_WIDTH-1:0]  HADDRS,
    input  logic [1:0]             HTRANSS,
    input  logic                   HWRITES,
    input  logic [2:0]             HSIZES,
    input  logic [2:0]             HBURSTS,
    input  logic [3:0]             HPROTS,
    input  logic                   HMASTLOCKS,
    input  logic [AUSER_WIDTH-1:0] HAUSERS,
    input  logic                   HREADYS,
    input  logic                   active_op,
    input  logic                   readyout_op,
    input  logic [1:0]             resp_op,
    output logic                   sel_op,
    output logic [ADDR_WIDTH-1:0]  addr_op,
    output logic [1:0]             trans_op,
    output logic                   write_op,
    output logic [2:0]             size_op,
    output logic [2:0]             burst_op,
    output logic [3:0]             prot_op,
    output logic                   mastlock_op,
    output logic [AUSER_WIDTH-1:0] auser_op,
    output logic                   ready_op,
    output logic                   held_tran_op,
    output logic                   HREADYOUTS,
    output logic [1:0]             HRESPS
);

    logic                   w_trans_req;
    logic                   w_capture;
    logic                   w_issue;
    logic                   w_dphase_next;
    logic                   r_pend;
    logic                   r_dphase;
    ahb_ctrl_t              w_live_ctrl;
    ahb_ctrl_t              w_hold_ctrl;
    logic [ADDR_WIDTH-1:0]  w_hold_addr;
    logic [AUSER_WIDTH-1:0] w_hold_auser;

    always_comb begin
        w_live_ctrl          = '0;
        w_live_ctrl.trans    = HTRANSS;
        w_live_ctrl.write    = HWRITES;
        w_live_ctrl.size     = HSIZES;
        w_live_ctrl.burst    = HBURSTS;
        w_live_ctrl.prot     = HPROTS;
        w_live_ctrl.mastlock = HMASTLOCKS;
    end

    // HREADYS gates the request, so capture only happens once any earlier
    // data phase of this master has completed.
    assign w_trans_req = HSELS & is_active_trans(HTRANSS) & HREADYS;
    assign w_capture   = w_trans_req & ~r_pend & ~active_op;
    assign w_issue     = r_pend & active_op;

    // A data phase is owned either by a live transfer accepted directly or by
    // the held transfer being accepted.
    assign w_dphase_next = (w_trans_req & active_op & ~r_pend) | w_issue;

    ahb_bm_hold_reg #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .AUSER_WIDTH (AUSER_WIDTH)
    ) u_hold_reg (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_load  (w_capture),
        .i_addr  (HADDRS),
        .i_auser (HAUSERS),
        .i_ctrl  (w_live_ctrl),
        .o_addr  (w_hold_addr),
        .o_auser (w_hold_auser),
        .o_ctrl  (w_hold_ctrl)
    );

    // Capture and issue are mutually exclusive: one needs r_pend low, the
    // other r_pend high.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend <= 1'b0;
        end else if (w_capture) begin
            r_pend <= 1'b1;
        end else if (w_issue) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dphase <= 1'b0;
        end else if (ready_op) begin
            r_dphase <= w_dphase_next;
        end
    end

    always_comb begin
        sel_op       = HSELS;
        addr_op      = HADDRS;
        trans_op     = HTRANSS;
        write_op     = HWRITES;
        size_op      = HSIZES;
        burst_op     = HBURSTS;
        prot_op      = HPROTS;
        mastlock_op  = HMASTLOCKS;
        auser_op     = HAUSERS;
        ready_op     = HREADYS;
        held_tran_op = r_pend;
        HREADYOUTS   = 1'b1;
        HRESPS       = HRESP_OKAY;
        if (r_pend) begin
            // The held copy is presented with a forced bus-ready so the
            // decoder treats it as a fresh address phase every cycle.
            sel_op      = 1'b1;
            addr_op     = w_hold_addr;
            trans_op    = w_hold_ctrl.trans;
            write_op    = w_hold_ctrl.write;
            size_op     = w_hold_ctrl.size;
            burst_op    = w_hold_ctrl.burst;
            prot_op     = w_hold_ctrl.prot;
            mastlock_op = w_hold_ctrl.mastlock;
            auser_op    = w_hold_auser;
            ready_op    = 1'b1;
            HREADYOUTS  = 1'b0;
            HRESPS      = HRESP_OKAY;
        end else if (r_dphase) begin
            HREADYOUTS = readyout_op;
            HRESPS     = resp_op;
        end
    end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// tb/tb_ahb_bm_input_stage.sv - directed self-checking bench for ahb_bm_input_stage
module tb_ahb_bm_input_stage;

    logic        HCLK;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic [31:0] HAUSERS;
    logic        HREADYS;
    logic        active_op;
    logic        readyout_op;
    logic [1:0]  resp_op;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic        mastlock_op;
    logic [31:0] auser_op;
    logic        ready_op;
    logic        held_tran_op;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_bm_input_stage #(
        .ADDR_WIDTH  (32),
        .AUSER_WIDTH (32)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HAUSERS      (HAUSERS),
        .HREADYS      (HREADYS),
        .active_op    (active_op),
        .readyout_op  (readyout_op),
        .resp_op      (resp_op),
        .sel_op       (sel_op),
        .addr_op      (addr_op),
        .trans_op     (trans_op),
        .write_op     (write_op),
        .size_op      (size_op),
        .burst_op     (burst_op),
        .prot_op      (prot_op),
        .mastlock_op  (mastlock_op),
        .auser_op     (auser_op),
        .ready_op     (ready_op),
        .held_tran_op (held_tran_op),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic drive_idle();
        HSELS       = 1'b0;
        HADDRS      = 32'h0;
        HTRANSS     = 2'b00;
        HWRITES     = 1'b0;
        HSIZES      = 3'b010;
        HBURSTS     = 3'b000;
        HPROTS      = 4'b0011;
        HMASTLOCKS  = 1'b0;
        HAUSERS     = 32'h0;
        HREADYS     = 1'b1;
        active_op   = 1'b0;
        readyout_op = 1'b1;
        resp_op     = 2'b00;
    endtask

    task automatic test_reset();
        drive_idle();
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        HADDRS = 32'h0000_1234;
        #1;
        n_checks++; if (held_tran_op !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b expected 0", held_tran_op); end
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b expected 1", HREADYOUTS); end
        n_checks++; if (HRESPS !== 2'b00) begin n_fail++; $display("FAIL reset_hresp: got %b expected 00", HRESPS); end
        n_checks++; if (addr_op !== 32'h0000_1234) begin n_fail++; $display("FAIL reset_passthru_addr: got %h expected 00001234", addr_op); end
        n_checks++; if (ready_op !== 1'b1) begin n_fail++; $display("FAIL reset_ready_op: got %b expected 1", ready_op); end
    endtask

    task automatic test_uncontended();
        @(posedge HCLK); #1;
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h2000_0000; HWRITES = 1'b1;
        HREADYS = 1'b1; active_op = 1'b1; readyout_op = 1'b1;
        #1;
        n_checks++; if (addr_op !== 32'h2000_0000) begin n_fail++; $display("FAIL unc_addr: got %h expected 20000000", addr_op); end
        n_checks++; if (held_tran_op !== 1'b0) begin n_fail++; $display("FAIL unc_held: got %b expected 0", held_tran_op); end
        n_checks++; if (trans_op !== 2'b10 || sel_op !== 1'b1 || write_op !== 1'b1) begin n_fail++; $display("FAIL unc_ctrl: got trans=%b sel=%b write=%b expected 10 1 1", trans_op, sel_op, write_op); end
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL unc_ready_addr_phase: got %b expected 1", HREADYOUTS); end
        // data phase with one wait state
        @(posedge HCLK); #1;
        HTRANSS = 2'b00; HADDRS = 32'h0; active_op = 1'b0; readyout_op = 1'b0; HREADYS = 1'b0;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL unc_dphase_wait: got %b expected 0", HREADYOUTS); end
        @(posedge HCLK); #1;
        readyout_op = 1'b1; HREADYS = 1'b1;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin n_fail++; $display("FAIL unc_dphase_done: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
    endtask

    task automatic test_contended_error();
        @(posedge HCLK); #1;
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h8000_0010; HWRITES = 1'b0;
        HREADYS = 1'b1; active_op = 1'b0; readyout_op = 1'b1; resp_op = 2'b00;
        #1;
        n_checks++; if (held_tran_op !== 1'b0 || addr_op !== 32'h8000_0010) begin n_fail++; $display("FAIL cont_capture_cycle: got held=%b addr=%h expected 0 80000010", held_tran_op, addr_op); end
        for (int i = 0; i < 3; i++) begin
            @(posedge HCLK); #1;
            HADDRS = 32'hDEAD_0000 + i; HTRANSS = 2'b00; HREADYS = 1'b0;
            active_op = (i == 2);
            #1;
            n_checks++; if (held_tran_op !== 1'b1) begin n_fail++; $display("FAIL cont_held[%0d]: got %b expected 1", i, held_tran_op); end
            n_checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b00) begin n_fail++; $display("FAIL cont_stall[%0d]: got %b/%b expected 0/00", i, HREADYOUTS, HRESPS); end
            n_checks++; if (addr_op !== 32'h8000_0010 || trans_op !== 2'b10) begin n_fail++; $display("FAIL cont_addr[%0d]: got %h/%b expected 80000010/10", i, addr_op, trans_op); end
            n_checks++; if (ready_op !== 1'b1 || sel_op !== 1'b1) begin n_fail++; $display("FAIL cont_ready_sel[%0d]: got %b/%b expected 1/1", i, ready_op, sel_op); end
        end
        // issued at the last edge; the slave answers with a two-cycle ERROR
        @(posedge HCLK); #1;
        HADDRS = 32'h0; active_op = 1'b0; readyout_op = 1'b0; resp_op = 2'b01; HREADYS = 1'b0;
        #1;
        n_checks++; if (held_tran_op !== 1'b0) begin n_fail++; $display("FAIL err_issued: got held=%b expected 0", held_tran_op); end
        n_checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin n_fail++; $display("FAIL err_cycle1: got %b/%b expected 0/01", HREADYOUTS, HRESPS); end
        @(posedge HCLK); #1;
        readyout_op = 1'b1; resp_op = 2'b01; HREADYS = 1'b1;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin n_fail++; $display("FAIL err_cycle2: got %b/%b expected 1/01", HREADYOUTS, HRESPS); end
    endtask

    task automatic test_idle();
        // IDLE while selected: no data phase is owned, decoder response ignored
        @(posedge HCLK); #1;
        HSELS = 1'b1; HTRANSS = 2'b00; active_op = 1'b1; readyout_op = 1'b0; resp_op = 2'b01; HREADYS = 1'b1;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin n_fail++; $display("FAIL idle_okay1: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
        @(posedge HCLK); #1;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00 || held_tran_op !== 1'b0) begin n_fail++; $display("FAIL idle_okay2: got %b/%b/%b expected 1/00/0", HREADYOUTS, HRESPS, held_tran_op); end
        drive_idle();
    endtask

    task automatic test_reset_mid_hold();
        @(posedge HCLK); #1;
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h4000_0000; HREADYS = 1'b1; active_op = 1'b0;
        @(posedge HCLK); #1;
        HTRANSS = 2'b00; HREADYS = 1'b0;
        #1;
        n_checks++; if (held_tran_op !== 1'b1) begin n_fail++; $display("FAIL rst_hold_setup: got %b expected 1", held_tran_op); end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        drive_idle();
        HADDRS = 32'h0000_0044;
        #1;
        n_checks++; if (held_tran_op !== 1'b0) begin n_fail++; $display("FAIL rst_hold_held: got %b expected 0", held_tran_op); end
        n_checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin n_fail++; $display("FAIL rst_hold_resp: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
        n_checks++; if (addr_op !== 32'h0000_0044) begin n_fail++; $display("FAIL rst_hold_addr: got %h expected 00000044", addr_op); end
    endtask

    task automatic test_back_to_back_burst();
        logic [31:0] exp_q[$];
        logic [31:0] act_q[$];
        logic [31:0] e;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            @(posedge HCLK); #1;
            HSELS = 1'b1; HTRANSS = (i == 0) ? 2'b10 : 2'b11; HBURSTS = 3'b011;
            HADDRS = 32'h3000_0100 + 32'(4 * i);
            HREADYS = 1'b1; active_op = 1'b0; readyout_op = 1'b1; resp_op = 2'b00;
            exp_q.push_back(HADDRS);
            #1;
            n_checks++; if (held_tran_op !== 1'b0 || HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL burst_present[%0d]: got held=%b rdy=%b expected 0 1", i, held_tran_op, HREADYOUTS); end
            for (int j = 0; j < 1 + (i % 2); j++) begin
                @(posedge HCLK); #1;
                HADDRS = 32'hBAD0_0000 + 32'(j); HTRANSS = 2'b11; HREADYS = 1'b0;
                active_op = (j == (i % 2));
                #1;
                n_checks++; if (held_tran_op !== 1'b1) begin n_fail++; $display("FAIL burst_held[%0d.%0d]: got %b expected 1", i, j, held_tran_op); end
                if (active_op && held_tran_op) act_q.push_back(addr_op);
            end
        end
        @(posedge HCLK); #1;
        drive_idle();
        #1;
        n_checks++; if (held_tran_op !== 1'b0) begin n_fail++; $display("FAIL burst_end_held: got %b expected 0", held_tran_op); end
        n_checks++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            n_checks++; if (a !== e) begin n_fail++; $display("FAIL burst_addr: got %h expected %h", a, e); end
        end
    endtask

    initial begin
        HRESET = 1'b1;
        drive_idle();
        test_reset();
        test_uncontended();
        test_contended_error();
        test_idle();
        test_reset_mid_hold();
        test_back_to_back_burst();
        repeat (2) @(posedge HCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
